// File: rtl/VX_tcu_pkg.sv
// ---------------------------------------------------------------------------
// VX_tcu_pkg: TCU format IDs, sizing constants and helpers for DRL mask sequencing.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package VX_tcu_pkg;

  localparam int TCU_MAX_INPUTS = 32;
  localparam int TCU_MIN_STRIDE = 1;
  localparam int TCU_MIN_TCK    = 2;
  localparam int TCU_IDX_W      = $clog2(TCU_MAX_INPUTS);

  localparam logic [3:0] TCU_FP32_ID = 4'd0;
  localparam logic [3:0] TCU_FP16_ID = 4'd1;
  localparam logic [3:0] TCU_BF16_ID = 4'd2;
  localparam logic [3:0] TCU_FP8_ID  = 4'd3;
  localparam logic [3:0] TCU_BF8_ID  = 4'd4;
  localparam logic [3:0] TCU_I8_ID   = 4'd9;
  localparam logic [3:0] TCU_U8_ID   = 4'd10;
  localparam logic [3:0] TCU_I4_ID   = 4'd11;
  localparam logic [3:0] TCU_U4_ID   = 4'd12;

  typedef enum logic [0:0] {
    SEQ_IDLE = 1'b0,
    SEQ_BUSY = 1'b1
  } tcu_seq_state_e;

  function automatic int tcu_max_chunks(input int tck);
    return (TCU_MAX_INPUTS + tck * TCU_MIN_STRIDE - 1) / (tck * TCU_MIN_STRIDE);
  endfunction

  function automatic int tcu_chunk_w(input int max_chunks);
    return (max_chunks > 1) ? $clog2(max_chunks) : 1;
  endfunction

  localparam int TCU_MAX_CHUNKS = tcu_max_chunks(TCU_MIN_TCK);
  localparam int TCU_CHUNK_W    = tcu_chunk_w(TCU_MAX_CHUNKS);

  // Zero marks an unsupported format.
  function automatic logic [2:0] tcu_fmt_stride(input logic [3:0] fmt);
    logic [2:0] s;
    case (fmt)
      TCU_FP32_ID, TCU_FP16_ID, TCU_BF16_ID:            s = 3'd4;
      TCU_FP8_ID, TCU_BF8_ID, TCU_I8_ID, TCU_U8_ID:     s = 3'd2;
      TCU_I4_ID, TCU_U4_ID:                             s = 3'd1;
      default:                                          s = 3'd0;
    endcase
    return s;
  endfunction

  function automatic int tcu_num_chunks(input logic [2:0] stride, input int tck);
    int n;
    case (stride)
      3'd1:    n = (TCU_MAX_INPUTS + tck - 1) / tck;
      3'd2:    n = (TCU_MAX_INPUTS + 2 * tck - 1) / (2 * tck);
      3'd4:    n = (TCU_MAX_INPUTS + 4 * tck - 1) / (4 * tck);
      default: n = 1;
    endcase
    return (n < 1) ? 1 : n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vx_tcu_drl_chunk_sel.sv
// ---------------------------------------------------------------------------
// vx_tcu_drl_chunk_sel: combinational extractor of one TCK-lane chunk of a strided mask.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vx_tcu_drl_chunk_sel
  import VX_tcu_pkg::*;
#(
  parameter int TCK = 4
) (
  input  logic [TCU_MAX_INPUTS-1:0] mask_i,
  input  logic [2:0]                stride_i,
  input  logic                      fp32_i,
  input  logic [TCU_CHUNK_W-1:0]    chunk_i,
  output logic [TCK-1:0]            lane_mask_o
);

  logic [31:0] idx;

  always_comb begin
    lane_mask_o = '0;
    idx         = '0;
    for (int i = 0; i < TCK; i++) begin
      idx = (32'(chunk_i) * 32'(TCK) + 32'(i)) * 32'(stride_i);
      // FP32 occupies lane pairs, so only even lanes carry an element.
      if ((stride_i != 3'd0) && (idx < 32'(TCU_MAX_INPUTS)) && !(fp32_i && i[0]))
        lane_mask_o[i] = mask_i[idx[TCU_IDX_W-1:0]];
    end
  end

endmodule

`default_nettype wire

// File: rtl/vx_tcu_drl_mask_seq.sv
// ---------------------------------------------------------------------------
// vx_tcu_drl_mask_seq: emits one registered TCK-lane mask per chunk of a request.
// Optional feature macro: TCU_DRL_SKIP_EMPTY_EN (skip all-zero chunks). Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vx_tcu_drl_mask_seq
  import VX_tcu_pkg::*;
#(
  parameter int N   = 2,
  parameter int TCK = 2 * N
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [TCU_MAX_INPUTS-1:0] vld_mask,
  input  logic [3:0]                fmt_s,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [TCK-1:0]            lane_mask,
  output logic [TCU_CHUNK_W-1:0]    chunk_idx,
  output logic                      last,
  output logic                      fmt_err
);

  localparam int MAX_CHUNKS = tcu_max_chunks(TCK);

  tcu_seq_state_e state_q, state_d;

  logic [TCU_MAX_INPUTS-1:0] mask_q;
  logic [2:0]                stride_q;
  logic                      fp32_q;
  logic [TCK-1:0]            lane_q;
  logic [TCU_CHUNK_W-1:0]    chunk_q;
  logic                      last_q;
  logic                      err_q;

  logic [2:0]                stride_in;
  logic                      fp32_in;
  logic                      accept;
  logic                      advance;
  logic                      load;
  logic [TCU_MAX_INPUTS-1:0] sel_mask;
  logic [2:0]                sel_stride;
  logic                      sel_fp32;
  logic [TCU_CHUNK_W-1:0]    nxt_chunk;
  logic                      nxt_last;
  logic [TCK-1:0]            nxt_lane;

  assign stride_in = tcu_fmt_stride(fmt_s);
  assign fp32_in   = (fmt_s == TCU_FP32_ID);

  assign valid_out = (state_q == SEQ_BUSY);
  assign ready_in  = !reset && (!valid_out || (ready_out && last_q));
  assign accept    = valid_in && ready_in;
  assign advance   = valid_out && ready_out && !last_q;
  assign load      = accept || advance;

  // A fresh capture computes its first beat straight from the request inputs.
  assign sel_mask   = accept ? vld_mask  : mask_q;
  assign sel_stride = accept ? stride_in : stride_q;
  assign sel_fp32   = accept ? fp32_in   : fp32_q;

`ifdef TCU_DRL_SKIP_EMPTY_EN
  logic [MAX_CHUNKS-1:0] nz_q;
  logic [MAX_CHUNKS-1:0] nz_in;
  logic [MAX_CHUNKS-1:0] nz_sel;
  logic [31:0]           nz_idx;
  int                    first_lb;

  always_comb begin
    nz_in  = '0;
    nz_idx = '0;
    for (int c = 0; c < MAX_CHUNKS; c++) begin
      for (int i = 0; i < TCK; i++) begin
        nz_idx = (32'(c) * 32'(TCK) + 32'(i)) * 32'(stride_in);
        if ((stride_in != 3'd0) && (nz_idx < 32'(TCU_MAX_INPUTS)) && !(fp32_in && i[0])
            && vld_mask[nz_idx[TCU_IDX_W-1:0]])
          nz_in[c] = 1'b1;
      end
    end
  end

  assign nz_sel = accept ? nz_in : nz_q;

  // Lowest nonzero chunk at or above the search base; chunk 0 when none remain.
  always_comb begin
    first_lb  = accept ? 0 : int'(chunk_q) + 1;
    nxt_chunk = '0;
    for (int c = MAX_CHUNKS - 1; c >= 0; c--) begin
      if (nz_sel[c] && (c >= first_lb))
        nxt_chunk = TCU_CHUNK_W'(c);
    end
    nxt_last = 1'b1;
    for (int c = 0; c < MAX_CHUNKS; c++) begin
      if (nz_sel[c] && (c > int'(nxt_chunk)))
        nxt_last = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      nz_q <= '0;
    else if (accept)
      nz_q <= nz_in;
  end
`else
  always_comb begin
    nxt_chunk = accept ? '0 : (chunk_q + 1'b1);
    nxt_last  = (int'(nxt_chunk) == (tcu_num_chunks(sel_stride, TCK) - 1));
  end
`endif

  vx_tcu_drl_chunk_sel #(
    .TCK (TCK)
  ) u_chunk_sel (
    .mask_i      (sel_mask),
    .stride_i    (sel_stride),
    .fp32_i      (sel_fp32),
    .chunk_i     (nxt_chunk),
    .lane_mask_o (nxt_lane)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE: if (accept) state_d = SEQ_BUSY;
      SEQ_BUSY: if (ready_out && last_q && !accept) state_d = SEQ_IDLE;
      default:  state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= SEQ_IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q   <= '0;
      stride_q <= '0;
      fp32_q   <= 1'b0;
      err_q    <= 1'b0;
      lane_q   <= '0;
      chunk_q  <= '0;
      last_q   <= 1'b0;
    end else begin
      if (accept) begin
        mask_q   <= vld_mask;
        stride_q <= stride_in;
        fp32_q   <= fp32_in;
        err_q    <= (stride_in == 3'd0);
      end
      if (load) begin
        lane_q  <= nxt_lane;
        chunk_q <= nxt_chunk;
        last_q  <= nxt_last;
      end
    end
  end

  assign lane_mask = lane_q;
  assign chunk_idx = chunk_q;
  assign last      = last_q;
  assign fmt_err   = err_q;

endmodule

`default_nettype wire
